// File: rtl/meter_frame_if.sv
// -----------------------------------------------------------------------------
// meter_frame_if
// Bundles the audio-sample / UI inputs and the frame-latched outputs of
// meter_frame_ctrl.
//   slave  : the controller side (samples, vsync, switches, pitch in;
//            bar/peak heights, latched UI state and frame_tick out)
//   master : the driving side (audio chain, VGA timing, UI) which also
//            consumes the frame outputs
// -----------------------------------------------------------------------------
interface meter_frame_if;
    logic               sample_valid;
    logic signed [15:0] sample_in;
    logic               vsync;
    logic [4:0]         sw_in;
    logic [11:0]        pitch_in;
    logic [15:0]        bar_height;
    logic [15:0]        peak_hold_height;
    logic [4:0]         sw_frame;
    logic [11:0]        pitch_frame;
    logic               frame_tick;

    modport slave (
        input  sample_valid, sample_in, vsync, sw_in, pitch_in,
        output bar_height, peak_hold_height, sw_frame, pitch_frame, frame_tick
    );

    modport master (
        output sample_valid, sample_in, vsync, sw_in, pitch_in,
        input  bar_height, peak_hold_height, sw_frame, pitch_frame, frame_tick
    );
endinterface

// File: rtl/meter_frame_ctrl.sv
// -----------------------------------------------------------------------------
// meter_frame_ctrl
// Frame-synchronous level meter controller in front of the color mapper.
// Tracks the peak |sample| seen during each video frame, scales it to a bar
// height (instant attack, stepped timed decay) and latches the UI switch and
// pitch state once per frame so the display never changes mid-scan.
//
// Ports:
//   clk    : pixel clock
//   reset  : asynchronous, active-high reset
//   mf     : meter_frame_if.slave
//            sample_valid/sample_in : audio sample strobe and signed sample
//            vsync                  : active-low VGA vsync (clk-synchronous)
//            sw_in/pitch_in         : raw UI state
//            bar_height             : bar height in pixels, 0..BAR_MAX
//            peak_hold_height       : peak-hold marker height
//            sw_frame/pitch_frame   : UI state latched at the frame boundary
//            frame_tick             : one-cycle pulse when the outputs update
//
// Optional feature: define METER_PEAK_HOLD_EN to build the peak-hold marker.
// Without it peak_hold_height is tied to 0.
//
// Update timing: T0 = cycle where vsync falls (snapshot), T1 = SCALE,
// T2 = APPLY, new outputs and frame_tick visible in T3.
// -----------------------------------------------------------------------------
module meter_frame_ctrl #(
    parameter int PEAK_SHIFT   = 7,
    parameter int BAR_MAX      = 380,
    parameter int DECAY_FRAMES = 2,
    parameter int DECAY_STEP   = 4,
    parameter int HOLD_FRAMES  = 30
) (
    input  logic          clk,
    input  logic          reset,
    meter_frame_if.slave  mf
);

    localparam logic [1:0] ST_ACCUM = 2'd0;
    localparam logic [1:0] ST_SCALE = 2'd1;
    localparam logic [1:0] ST_APPLY = 2'd2;

    localparam logic [15:0] BAR_MAX_W    = 16'(BAR_MAX);
    localparam logic [15:0] DECAY_STEP_W = 16'(DECAY_STEP);
    localparam logic [3:0]  DECAY_LAST   = 4'(DECAY_FRAMES - 1);

    logic [1:0]  state_reg;
    logic        vsync_q_reg;
    logic [14:0] peak_acc_reg;
    logic [14:0] peak_snap_reg;
    logic [15:0] target_reg;
    logic [15:0] bar_reg;
    logic [3:0]  decay_cnt_reg;
    logic [4:0]  sw_frame_reg;
    logic [11:0] pitch_frame_reg;
    logic        frame_tick_reg;

    logic [15:0] neg_sample;
    logic [14:0] mag;
    logic [14:0] peak_max;
    logic        frame_edge;
    logic [15:0] scaled;
    logic [15:0] target_next;
    logic [15:0] bar_minus;
    logic [15:0] bar_decayed;
    logic [15:0] bar_next;
    logic [3:0]  decay_cnt_next;

    // |sample|; the only value whose negation overflows is -32768, which
    // saturates to the largest 15-bit magnitude.
    always_comb begin
        neg_sample = ~mf.sample_in + 16'd1;
        if (!mf.sample_in[15]) begin
            mag = mf.sample_in[14:0];
        end else if (neg_sample[15]) begin
            mag = 15'h7FFF;
        end else begin
            mag = neg_sample[14:0];
        end
        peak_max = (mf.sample_valid && (mag > peak_acc_reg)) ? mag : peak_acc_reg;
    end

    assign frame_edge = vsync_q_reg & ~mf.vsync;

    always_comb begin
        scaled      = {1'b0, peak_snap_reg} >> PEAK_SHIFT;
        target_next = (scaled > BAR_MAX_W) ? BAR_MAX_W : scaled;
    end

    // Decay never crosses below the new target nor below zero.
    always_comb begin
        bar_minus      = (bar_reg > DECAY_STEP_W) ? (bar_reg - DECAY_STEP_W) : 16'd0;
        bar_decayed    = (bar_minus > target_reg) ? bar_minus : target_reg;
        bar_next       = bar_reg;
        decay_cnt_next = decay_cnt_reg;
        if (target_reg >= bar_reg) begin
            bar_next       = target_reg;
            decay_cnt_next = 4'd0;
        end else if (decay_cnt_reg == DECAY_LAST) begin
            bar_next       = bar_decayed;
            decay_cnt_next = 4'd0;
        end else begin
            decay_cnt_next = decay_cnt_reg + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_ACCUM;
            vsync_q_reg     <= 1'b1;
            peak_acc_reg    <= '0;
            peak_snap_reg   <= '0;
            target_reg      <= '0;
            bar_reg         <= '0;
            decay_cnt_reg   <= '0;
            sw_frame_reg    <= '0;
            pitch_frame_reg <= '0;
            frame_tick_reg  <= 1'b0;
        end else begin
            vsync_q_reg    <= mf.vsync;
            frame_tick_reg <= 1'b0;

            // A sample arriving on the edge cycle also seeds the new frame.
            if ((state_reg == ST_ACCUM) && frame_edge) begin
                peak_acc_reg <= mf.sample_valid ? mag : 15'd0;
            end else begin
                peak_acc_reg <= peak_max;
            end

            case (state_reg)
                ST_ACCUM: begin
                    if (frame_edge) begin
                        peak_snap_reg <= peak_max;
                        state_reg     <= ST_SCALE;
                    end
                end
                ST_SCALE: begin
                    target_reg <= target_next;
                    state_reg  <= ST_APPLY;
                end
                ST_APPLY: begin
                    bar_reg         <= bar_next;
                    decay_cnt_reg   <= decay_cnt_next;
                    sw_frame_reg    <= mf.sw_in;
                    pitch_frame_reg <= mf.pitch_in;
                    frame_tick_reg  <= 1'b1;
                    state_reg       <= ST_ACCUM;
                end
                default: begin
                    state_reg <= ST_ACCUM;
                end
            endcase
        end
    end

`ifdef METER_PEAK_HOLD_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);

    logic [15:0] hold_reg;
    logic [7:0]  hold_cnt_reg;

    // Marker jumps up with the target, otherwise waits HOLD_FRAMES updates
    // and then drops to the bar value being written in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_reg     <= '0;
            hold_cnt_reg <= '0;
        end else if (state_reg == ST_APPLY) begin
            if (target_reg > hold_reg) begin
                hold_reg     <= target_reg;
                hold_cnt_reg <= 8'd0;
            end else if (hold_cnt_reg == HOLD_LAST) begin
                hold_reg     <= bar_next;
                hold_cnt_reg <= 8'd0;
            end else begin
                hold_cnt_reg <= hold_cnt_reg + 8'd1;
            end
        end
    end

    assign mf.peak_hold_height = hold_reg;
`else
    assign mf.peak_hold_height = 16'd0;
`endif

    assign mf.bar_height  = bar_reg;
    assign mf.sw_frame    = sw_frame_reg;
    assign mf.pitch_frame = pitch_frame_reg;
    assign mf.frame_tick  = frame_tick_reg;

endmodule

// File: tb/tb_meter_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_meter_frame_ctrl
// Drives sample frames into meter_frame_ctrl, predicts each frame update with
// a behavioural model, queues the prediction at the vsync edge and compares
// it when frame_tick appears. A second instance with BAR_MAX=200 shares the
// stimulus to show bar saturation.
// -----------------------------------------------------------------------------
module tb_meter_frame_ctrl;

    localparam int PEAK_SHIFT   = 7;
    localparam int BAR_MAX      = 380;
    localparam int DECAY_FRAMES = 2;
    localparam int DECAY_STEP   = 4;
    localparam int HOLD_FRAMES  = 30;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    meter_frame_if mi ();
    meter_frame_if m2 ();

    meter_frame_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .mf    (mi)
    );

    meter_frame_ctrl #(.BAR_MAX(200)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .mf    (m2)
    );

    assign m2.sample_valid = mi.sample_valid;
    assign m2.sample_in    = mi.sample_in;
    assign m2.vsync        = mi.vsync;
    assign m2.sw_in        = mi.sw_in;
    assign m2.pitch_in     = mi.pitch_in;

    typedef struct {
        int                 n;
        logic signed [15:0] s0;
        logic signed [15:0] s1;
        logic signed [15:0] s2;
        logic [4:0]         sw;
        logic [11:0]        pitch;
        int                 exp_bar;
    } vec_t;

    typedef struct {
        int          bar;
        int          hold;
        logic [4:0]  sw;
        logic [11:0] pitch;
        longint      cyc;
    } exp_t;

    exp_t   exp_q[$];
    vec_t   vecs[8];
    int     n_tests = 0;
    int     n_fail  = 0;
    int     tick_cnt = 0;
    longint cyc = 0;
    logic   prev_tick = 1'b0;

    int m_bar, m_dcnt, m_hold, m_hcnt, frame_peak;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int mag_of(input logic signed [15:0] v);
        int m;
        m = int'(v);
        if (m < 0) m = -m;
        if (m > 32767) m = 32767;
        return m;
    endfunction

    task automatic model_update(input int peak);
        int t;
        t = peak >> PEAK_SHIFT;
        if (t > BAR_MAX) t = BAR_MAX;
        if (t >= m_bar) begin
            m_bar  = t;
            m_dcnt = 0;
        end else begin
            m_dcnt++;
            if (m_dcnt >= DECAY_FRAMES) begin
                m_dcnt = 0;
                m_bar  = (m_bar - DECAY_STEP < t) ? t : m_bar - DECAY_STEP;
                if (m_bar < 0) m_bar = 0;
            end
        end
`ifdef METER_PEAK_HOLD_EN
        if (t > m_hold) begin
            m_hold = t;
            m_hcnt = 0;
        end else if (m_hcnt == HOLD_FRAMES - 1) begin
            m_hold = m_bar;
            m_hcnt = 0;
        end else begin
            m_hcnt++;
        end
`else
        m_hold = 0;
`endif
    endtask

    task automatic push_expect(input int peak);
        exp_t e;
        model_update(peak);
        e.bar   = m_bar;
        e.hold  = m_hold;
        e.sw    = mi.sw_in;
        e.pitch = mi.pitch_in;
        e.cyc   = cyc;
        exp_q.push_back(e);
    endtask

    // All stimulus tasks start and end right after a falling clock edge.
    task automatic send_sample(input logic signed [15:0] v);
        mi.sample_valid = 1'b1;
        mi.sample_in    = v;
        if (mag_of(v) > frame_peak) frame_peak = mag_of(v);
        @(negedge clk);
        mi.sample_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("tick_timeout", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic do_frame(input bit ev, input logic signed [15:0] es, input int low_cycles);
        int peak;
        peak = frame_peak;
        if (ev && mag_of(es) > peak) peak = mag_of(es);
        push_expect(peak);
        mi.vsync        = 1'b0;
        mi.sample_valid = ev;
        mi.sample_in    = es;
        frame_peak      = ev ? mag_of(es) : 0;
        @(negedge clk);
        mi.sample_valid = 1'b0;
        repeat (low_cycles - 1) @(negedge clk);
        mi.vsync = 1'b1;
        wait_drain();
        @(negedge clk);
    endtask

    // Scoreboard consumer: every frame_tick pops one prediction.
    always @(negedge clk) begin
        if (reset) begin
            prev_tick = 1'b0;
        end else begin
            if (mi.frame_tick) begin
                exp_t e;
                tick_cnt++;
                check("tick_width", prev_tick, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_tick", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    $display("[TB] tick bar=%0d hold=%0d sw=%b pitch=%h (exp bar=%0d hold=%0d)",
                             mi.bar_height, mi.peak_hold_height, mi.sw_frame, mi.pitch_frame,
                             e.bar, e.hold);
                    check("tick_latency", cyc - e.cyc, 3);
                    check("bar_height", mi.bar_height, e.bar);
                    check("peak_hold_height", mi.peak_hold_height, e.hold);
                    check("sw_frame", mi.sw_frame, e.sw);
                    check("pitch_frame", mi.pitch_frame, e.pitch);
                end
            end
            prev_tick = mi.frame_tick;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        vecs[0] = '{3, 16'sd1000, -16'sd6400, 16'sd300, 5'b00001, 12'h000, 50};
        vecs[1] = '{1, -16'sd32768, 16'sd0, 16'sd0, 5'b00010, 12'h123, 255};
        vecs[2] = '{2, 16'sd32767, 16'sd0, 16'sd0, 5'b00100, 12'h456, 255};
        vecs[3] = '{1, 16'sd12800, 16'sd0, 16'sd0, 5'b01000, 12'h789, 255};
        vecs[4] = '{1, 16'sd12800, 16'sd0, 16'sd0, 5'b10000, 12'hABC, 251};
        vecs[5] = '{1, -16'sd32767, 16'sd0, 16'sd0, 5'b00011, 12'h0FF, 255};
        vecs[6] = '{1, 16'sd127, 16'sd0, 16'sd0, 5'b11111, 12'hFFF, 255};
        vecs[7] = '{1, -16'sd128, 16'sd0, 16'sd0, 5'b00000, 12'h001, 251};

        m_bar = 0; m_dcnt = 0; m_hold = 0; m_hcnt = 0; frame_peak = 0;
        reset           = 1'b1;
        mi.vsync        = 1'b1;
        mi.sample_valid = 1'b0;
        mi.sample_in    = '0;
        mi.sw_in        = '0;
        mi.pitch_in     = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state and idle behaviour
        check("rst_bar", mi.bar_height, 0);
        check("rst_hold", mi.peak_hold_height, 0);
        check("rst_sw", mi.sw_frame, 0);
        check("rst_pitch", mi.pitch_frame, 0);
        check("rst_tick", mi.frame_tick, 0);
        repeat (1000) @(negedge clk);
        check("idle_no_tick", tick_cnt, 0);
        check("idle_bar", mi.bar_height, 0);

        // Table-driven frames
        for (int i = 0; i < 8; i++) begin
            mi.sw_in    = vecs[i].sw;
            mi.pitch_in = vecs[i].pitch;
            if (vecs[i].n > 0) send_sample(vecs[i].s0);
            if (vecs[i].n > 1) send_sample(vecs[i].s1);
            if (vecs[i].n > 2) send_sample(vecs[i].s2);
            repeat (2) @(negedge clk);
            do_frame(1'b0, 16'sd0, 4);
            check($sformatf("vec%0d_bar", i), mi.bar_height, vecs[i].exp_bar);
            if (i == 1) check("bar_max_saturate", m2.bar_height, 200);
        end

        // Sample on the edge cycle counts in both the closing and the new frame
        do_frame(1'b1, 16'sd25600, 4);
        check("edge_sample_frame_a", mi.bar_height, 251);
        do_frame(1'b0, 16'sd0, 4);
        check("edge_sample_frame_b", mi.bar_height, 247);

        // Second falling edge while in APPLY must not queue an update
        t0 = tick_cnt;
        push_expect(frame_peak);
        frame_peak = 0;
        mi.vsync = 1'b0;
        @(negedge clk);
        mi.vsync = 1'b1;
        @(negedge clk);
        mi.vsync = 1'b0;
        repeat (4) @(negedge clk);
        mi.vsync = 1'b1;
        repeat (10) @(negedge clk);
        wait_drain();
        check("edge_in_apply_ignored", tick_cnt - t0, 1);

        // vsync held low: one update only
        t0 = tick_cnt;
        do_frame(1'b0, 16'sd0, 50);
        repeat (10) @(negedge clk);
        check("vsync_low_single", tick_cnt - t0, 1);

        // UI state changes mid-frame only appear after the next update
        mi.sw_in    = 5'b00001;
        mi.pitch_in = 12'h000;
        do_frame(1'b0, 16'sd0, 4);
        mi.sw_in    = 5'b01000;
        mi.pitch_in = 12'hABC;
        repeat (20) @(negedge clk);
        check("sw_hold_midframe", mi.sw_frame, 5'b00001);
        check("pitch_hold_midframe", mi.pitch_frame, 12'h000);
        do_frame(1'b0, 16'sd0, 4);
        check("sw_after_edge", mi.sw_frame, 5'b01000);
        check("pitch_after_edge", mi.pitch_frame, 12'hABC);

        // Asynchronous reset while the update is in flight
        t0 = tick_cnt;
        check("pre_reset_bar_nonzero", (mi.bar_height != 0), 1);
        mi.vsync = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("async_reset_bar", mi.bar_height, 0);
        check("async_reset_sw", mi.sw_frame, 0);
        @(negedge clk);
        mi.vsync = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_bar = 0; m_dcnt = 0; m_hold = 0; m_hcnt = 0; frame_peak = 0;
        repeat (6) @(negedge clk);
        check("reset_aborts_update", tick_cnt - t0, 0);
        check("reset_tick_low", mi.frame_tick, 0);

        // Decay from 50 to 0 over 26 silent frames
        send_sample(-16'sd6400);
        do_frame(1'b0, 16'sd0, 4);
        check("decay_start", mi.bar_height, 50);
        for (int k = 1; k <= 28; k++) begin
            do_frame(1'b0, 16'sd0, 4);
            if (k == 2)  check("decay_frame2", mi.bar_height, 46);
            if (k == 4)  check("decay_frame4", mi.bar_height, 42);
            if (k == 26) check("decay_frame26", mi.bar_height, 0);
        end
        check("decay_floor", mi.bar_height, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
